// File: rtl/alu_pkg.sv
// Opcode constants and execute-stage state encoding shared with the ALU control stage.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] MUL = 4'd2;
    localparam logic [3:0] AND = 4'd3;
    localparam logic [3:0] OR  = 4'd4;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } exec_state_t;

    // Two's-complement overflow from sign bits; for subtraction pass the inverted sign of b.
    function automatic logic signed_overflow(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer: one iteration per cycle for WIDTH cycles after start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] accumulator;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    counter;
    logic             busy;

    // The product is presented combinationally so the final iteration's addition lands in the result on the done edge.
    always_comb begin
        acc_next = accumulator + (multiplier[0] ? multiplicand : '0);
    end

    assign done    = busy && (counter == LAST);
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            counter      <= '0;
            busy         <= 1'b0;
        end else if (start) begin
            multiplicand <= a;
            multiplier   <= b;
            accumulator  <= '0;
            counter      <= '0;
            busy         <= 1'b1;
        end else if (busy) begin
            accumulator  <= acc_next;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            if (counter == LAST) begin
                counter <= '0;
                busy    <= 1'b0;
            end else begin
                counter <= counter + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ADD/SUB/AND/OR, multi-cycle MUL, registered result with valid/ready.
// Optional feature: define ALU_EXEC_OVERFLOW_EN to add the registered signed 'overflow' output.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ctrl_command,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ALU_EXEC_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    exec_state_t      state;
    exec_state_t      next_state;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (ctrl_command == MUL);
    assign mul_start = accept && is_mul;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (operand_a),
        .b      (operand_b),
        .done   (mul_done),
        .product(mul_product)
    );

    // Unlisted opcodes fall back to ADD.
    always_comb begin
        alu_res = operand_a + operand_b;
        case (ctrl_command)
            SUB:     alu_res = operand_a - operand_b;
            AND:     alu_res = operand_a & operand_b;
            OR:      alu_res = operand_a | operand_b;
            default: alu_res = operand_a + operand_b;
        endcase
    end

`ifdef ALU_EXEC_OVERFLOW_EN
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        case (ctrl_command)
            SUB:          alu_ovf = signed_overflow(operand_a[WIDTH-1], ~operand_b[WIDTH-1], alu_res[WIDTH-1]);
            MUL, AND, OR: alu_ovf = 1'b0;
            default:      alu_ovf = signed_overflow(operand_a[WIDTH-1], operand_b[WIDTH-1], alu_res[WIDTH-1]);
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mul_start) next_state = MUL_RUN;
            MUL_RUN: if (mul_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new accept on the consume edge replaces the old result rather than clearing out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (accept && !is_mul) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            out_valid <= 1'b1;
`ifdef ALU_EXEC_OVERFLOW_EN
            overflow  <= alu_ovf;
`endif
        end else if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            out_valid <= 1'b1;
`ifdef ALU_EXEC_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, MUL/backpressure/reset sequences, random ops vs model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ctrl_command = 4'd0;
    logic [WIDTH-1:0] operand_a = '0;
    logic [WIDTH-1:0] operand_b = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
    logic             overflow;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]       cmd;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             zr;
        logic             ovf;
    } vec_t;

    vec_t vecs[5];

    alu_exec_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_command(ctrl_command),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .zero        (zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef ALU_EXEC_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: plain arithmetic on the opcode meaning.
    function automatic logic [WIDTH-1:0] model_result(input logic [3:0] cmd, input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        case (cmd)
            SUB:     return a - b;
            MUL:     return a * b;
            AND:     return a & b;
            OR:      return a | b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic model_overflow(input logic [3:0] cmd, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        longint sa  = longint'($signed(a));
        longint sb  = longint'($signed(b));
        longint lim = 64'sh7FFFFFFF;
        longint s;
        case (cmd)
            MUL, AND, OR: return 1'b0;
            SUB:          s = sa - sb;
            default:      s = sa + sb;
        endcase
        return (s > lim) || (s < -lim - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] cmd, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ctrl_command = cmd;
        operand_a    = a;
        operand_b    = b;
        in_valid     = 1'b1;
    endtask

    // Presents an op, waits (bounded) for in_ready, returns just after the accept edge.
    task automatic accept_op(input logic [3:0] cmd, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        apply_stimulus(cmd, a, b);
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check_bit("accept_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < WIDTH + 8) begin
            tick();
            n++;
        end
        check_bit(name, out_valid, 1'b1);
    endtask

    task automatic run_mul(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] expected);
        int stall_bad = 0;
        out_ready = 1'b1;
        accept_op(MUL, a, b);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_ready || out_valid) stall_bad++;
            tick();
        end
        check_count({name, "_stall_cycles_bad"}, stall_bad, 0);
        check_bit({name, "_out_valid"}, out_valid, 1'b1);
        check_output({name, "_result"}, result, expected);
        check_bit({name, "_zero"}, zero, expected == '0);
        tick();
    endtask

    initial begin
        logic [3:0]       cmd;
        logic [WIDTH-1:0] ra, rb, exp_res;
        int               hold_bad;

        vecs[0] = '{ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1] = '{SUB,   32'd5,        32'd5,        32'd0,        1'b1, 1'b0};
        vecs[2] = '{AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
        vecs[3] = '{OR,    32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0};
        vecs[4] = '{4'd9,  32'd2,        32'd3,        32'd5,        1'b0, 1'b0};

        // Reset held for two cycles.
        tick();
        tick();
        check_output("reset_result", result, '0);
        check_bit("reset_zero", zero, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("reset_in_ready", in_ready, 1'b1);

        // Directed single-cycle vectors, one-cycle latency.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].cmd, vecs[i].a, vecs[i].b);
            check_bit($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            check_bit($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check_output($sformatf("vec%0d_result", i), result, vecs[i].res);
            check_bit($sformatf("vec%0d_zero", i), zero, vecs[i].zr);
`ifdef ALU_EXEC_OVERFLOW_EN
            check_bit($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
`endif
        end
        tick();
        check_bit("drain_out_valid", out_valid, 1'b0);

        run_mul("mul_1234x5678", 32'd1234, 32'd5678, 32'd7006652);
        run_mul("mul_all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Backpressure with a queued OR accepted on the consume edge.
        out_ready = 1'b0;
        accept_op(ADD, 32'd1, 32'd1);
        apply_stimulus(OR, 32'h10, 32'h01);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (result !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
            tick();
        end
        check_count("backpressure_hold_bad", hold_bad, 0);
        out_ready = 1'b1;
        #1;
        check_bit("backpressure_release_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_output("backpressure_queued_or", result, 32'h11);
        check_bit("backpressure_queued_valid", out_valid, 1'b1);
        tick();
        check_bit("backpressure_consumed", out_valid, 1'b0);

        // Reset at MUL iteration 10 aborts without presenting a partial product.
        accept_op(MUL, 32'd1234, 32'd5678);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_bit("abort_out_valid", out_valid, 1'b0);
        check_output("abort_result", result, '0);
        check_bit("abort_in_ready", in_ready, 1'b1);
        hold_bad = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            if (out_valid) hold_bad++;
            tick();
        end
        check_count("abort_no_stale_valid", hold_bad, 0);
        accept_op(ADD, 32'd3, 32'd4);
        check_bit("abort_add_valid", out_valid, 1'b1);
        check_output("abort_add_result", result, 32'd7);
        tick();

        // Four back-to-back single-cycle ops.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd = (i == 0) ? ADD : (i == 1) ? SUB : (i == 2) ? AND : OR;
            ra  = 32'h100 + 32'(i * 7);
            rb  = 32'h0F0 + 32'(i);
            apply_stimulus(cmd, ra, rb);
            check_bit($sformatf("b2b%0d_in_ready", i), in_ready, 1'b1);
            tick();
            check_bit($sformatf("b2b%0d_valid", i), out_valid, 1'b1);
            check_output($sformatf("b2b%0d_result", i), result, model_result(cmd, ra, rb));
        end
        in_valid = 1'b0;
        tick();

        // Randomised ops with random backpressure against the model.
        for (int i = 0; i < 150; i++) begin
            cmd = ($urandom_range(0, 3) == 0) ? MUL : 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = '0;
            exp_res   = model_result(cmd, ra, rb);
            out_ready = 1'b0;
            accept_op(cmd, ra, rb);
            wait_valid($sformatf("rand%0d_valid", i));
            hold_bad = 0;
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                tick();
                if (!out_valid || in_ready || result !== exp_res) hold_bad++;
            end
            check_count($sformatf("rand%0d_hold_bad", i), hold_bad, 0);
            check_output($sformatf("rand%0d_result", i), result, exp_res);
            check_bit($sformatf("rand%0d_zero", i), zero, exp_res == '0);
`ifdef ALU_EXEC_OVERFLOW_EN
            check_bit($sformatf("rand%0d_overflow", i), overflow, model_overflow(cmd, ra, rb));
`endif
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
